// File: rtl/max7219_if_arbiter.sv
// max7219_if_arbiter: shares one max7219_if serial driver between G_NB_REQ
// requesters. A requester owns the driver for a burst of frames. Grants are
// round-robin by default. Define MAX7219_IF_ARB_FIXED_PRIO_EN to use fixed
// priority instead, where the lowest-index requester always wins.
// An idle watchdog revokes the grant from an owner that never issues start.
// Handshake: the owner's i_start is accepted only in GRANT. It is forwarded
// to the driver one cycle later. The driver's done is accepted only in XFER.
// It comes back as a single o_done pulse to the owner one cycle later.
`timescale 1ns/1ps
module max7219_if_arbiter #(
    parameter int G_NB_REQ        = 3,
    parameter int G_DATA_WIDTH    = 16,
    parameter int G_IDLE_TIMEOUT  = 1024,
    parameter int G_TIMEOUT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [G_NB_REQ-1:0]              i_req,
    output logic [G_NB_REQ-1:0]              o_gnt,
    input  logic [G_NB_REQ-1:0]              i_start,
    input  logic [G_NB_REQ-1:0]              i_en_load,
    input  logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_data,
    output logic [G_NB_REQ-1:0]              o_done,
    output logic                             o_max7219_if_start,
    output logic                             o_max7219_if_en_load,
    output logic [G_DATA_WIDTH-1:0]          o_max7219_if_data,
    input  logic                             i_max7219_if_done,
    output logic [2:0]                       o_owner,
    output logic                             o_busy,
    output logic                             o_timeout,
    output logic [1:0]                       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [G_TIMEOUT_WIDTH-1:0] LP_WD_LIMIT = G_TIMEOUT_WIDTH'(G_IDLE_TIMEOUT);
    localparam logic [G_TIMEOUT_WIDTH-1:0] LP_WD_ONE   = G_TIMEOUT_WIDTH'(1);
    localparam logic [2:0]                 LP_LAST_IDX = 3'(G_NB_REQ - 1);

    state_t                      state_q, state_d;
    logic [G_NB_REQ-1:0]         gnt_q, gnt_d;
    logic [2:0]                  owner_q, owner_d;
    logic                        busy_q, busy_d;
    logic                        start_q, start_d;
    logic                        en_load_q, en_load_d;
    logic [G_DATA_WIDTH-1:0]     data_q, data_d;
    logic [G_NB_REQ-1:0]         done_q, done_d;
    logic                        timeout_q, timeout_d;
    logic [2:0]                  rr_q, rr_d;
    logic [G_TIMEOUT_WIDTH-1:0]  wd_q, wd_d;

    // Arbitration winner and the owner's view of the shared request bundle.
    logic                        win_found;
    logic [2:0]                  win_idx;
    logic [G_NB_REQ-1:0]         win_oh;
    logic                        own_req;
    logic                        own_start;
    logic                        own_en_load;
    logic [G_DATA_WIDTH-1:0]     own_data;
    logic                        wd_expire;

    // Pick the winner: the first request at or above the RR pointer, else the lowest one.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
`ifndef MAX7219_IF_ARB_FIXED_PRIO_EN
        for (int k = 0; k < G_NB_REQ; k++) begin
            if (!win_found && i_req[k] && (3'(k) >= rr_q)) begin
                win_found = 1'b1;
                win_idx   = 3'(k);
                win_oh[k] = 1'b1;
            end
        end
`endif
        for (int k = 0; k < G_NB_REQ; k++) begin
            if (!win_found && i_req[k]) begin
                win_found = 1'b1;
                win_idx   = 3'(k);
                win_oh[k] = 1'b1;
            end
        end
    end

    // Mux the owner's signals through the one-hot grant.
    always_comb begin
        own_data = '0;
        for (int k = 0; k < G_NB_REQ; k++) begin
            if (gnt_q[k]) begin
                own_data = i_data[k*G_DATA_WIDTH +: G_DATA_WIDTH];
            end
        end
        own_req     = |(i_req & gnt_q);
        own_start   = |(i_start & gnt_q);
        own_en_load = |(i_en_load & gnt_q);
        wd_expire   = (G_IDLE_TIMEOUT != 0) && ((wd_q + LP_WD_ONE) == LP_WD_LIMIT);
    end

    // Next-state and registered-output logic of the grant FSM.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        start_d   = 1'b0;
        en_load_d = en_load_q;
        data_d    = data_q;
        done_d    = '0;
        timeout_d = 1'b0;
        rr_d      = rr_q;
        wd_d      = wd_q;
        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (win_found) begin
                    gnt_d   = win_oh;
                    owner_d = win_idx;
                    busy_d  = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A start wins over a simultaneous request drop. The drop is then seen after done.
                if (own_start) begin
                    data_d    = own_data;
                    en_load_d = own_en_load;
                    start_d   = 1'b1;
                    wd_d      = '0;
                    state_d   = ST_XFER;
                end else if (!own_req) begin
                    state_d = ST_RELEASE;
                end else if (wd_expire) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else if (G_IDLE_TIMEOUT != 0) begin
                    wd_d = wd_q + LP_WD_ONE;
                end
            end
            ST_XFER: begin
                if (i_max7219_if_done) begin
                    done_d  = gnt_q;
                    state_d = own_req ? ST_GRANT : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                gnt_d     = '0;
                busy_d    = 1'b0;
                en_load_d = 1'b0;
                wd_d      = '0;
                rr_d      = (owner_q >= LP_LAST_IDX) ? 3'd0 : owner_q + 3'd1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            en_load_q <= 1'b0;
            data_q    <= '0;
            done_q    <= '0;
            timeout_q <= 1'b0;
            rr_q      <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            en_load_q <= en_load_d;
            data_q    <= data_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            rr_q      <= rr_d;
            wd_q      <= wd_d;
        end
    end

    assign o_gnt                = gnt_q;
    assign o_owner              = owner_q;
    assign o_busy               = busy_q;
    assign o_done               = done_q;
    assign o_timeout            = timeout_q;
    assign o_max7219_if_start   = start_q;
    assign o_max7219_if_en_load = en_load_q;
    assign o_max7219_if_data    = data_q;
    assign o_dbg_state          = state_q;

endmodule

// File: tb/tb_max7219_if_arbiter.sv
// Bench for max7219_if_arbiter: directed table, hand-written corner sequences,
// and a randomized run checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_max7219_if_arbiter;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int TO = 16;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   i_req, i_start, i_en_load, o_gnt, o_done;
    logic [N*W-1:0] i_data;
    logic           drv_start, drv_en_load, drv_done;
    logic [W-1:0]   drv_data;
    logic [2:0]     o_owner;
    logic           o_busy, o_timeout;
    logic [1:0]     dbg_state;

    always #5 clk = ~clk;

    max7219_if_arbiter #(
        .G_NB_REQ(N), .G_DATA_WIDTH(W), .G_IDLE_TIMEOUT(TO), .G_TIMEOUT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .o_gnt(o_gnt),
        .i_start(i_start), .i_en_load(i_en_load), .i_data(i_data),
        .o_done(o_done),
        .o_max7219_if_start(drv_start), .o_max7219_if_en_load(drv_en_load),
        .o_max7219_if_data(drv_data), .i_max7219_if_done(drv_done),
        .o_owner(o_owner), .o_busy(o_busy), .o_timeout(o_timeout),
        .o_dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [W:0]  exp_q[$];   // {en_load, data} of frames the owner started

    typedef struct {
        logic [N-1:0] req;
        logic [W-1:0] data;
        logic         en;
        logic [N-1:0] exp_gnt;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int k, input logic [W-1:0] d, input logic en);
        i_start[k]         = 1'b1;
        i_en_load[k]       = en;
        i_data[k*W +: W]   = d;
    endtask

    task automatic clear_inputs();
        i_req     = '0;
        i_start   = '0;
        i_en_load = '0;
        i_data    = '0;
        drv_done  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_gnt"},     32'(o_gnt), 0);
        check({name, "_busy"},    32'(o_busy), 0);
        check({name, "_owner"},   32'(o_owner), 0);
        check({name, "_done"},    32'(o_done), 0);
        check({name, "_start"},   32'(drv_start), 0);
        check({name, "_en_load"}, 32'(drv_en_load), 0);
        check({name, "_data"},    32'(drv_data), 0);
        check({name, "_timeout"}, 32'(o_timeout), 0);
    endtask

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        if (k >= 0 && k < N) v[k] = 1'b1;
        return v;
    endfunction

    function automatic int oh_index(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    // Reference arbitration: next winner after the last owner, or lowest index.
    function automatic int model_winner(input logic [N-1:0] req, input int last);
`ifdef MAX7219_IF_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (req[i]) return i;
`else
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (last + i) % N;
            if (req[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    // Bound on total run time.
    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- random-run model state ----------------
    logic [N-1:0] prev_req, prev_gnt, exp_done;
    logic         exp_start, in_flight, owner_dropped, drv_active, drain;
    int           m_last, m_owner, idle_cnt, drv_cnt, r, sk, n_grants;
    logic [W-1:0] rd;
    logic         ren;
    logic [W:0]   fr_exp;

    initial begin
        logic [W-1:0] frames[3];
        int           ord[4];
        int           eo;
        logic         sticky;

        frames[0] = 16'h0C01; frames[1] = 16'h0F00; frames[2] = 16'h0101;

        // ---- reset ----
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        check("reset_state", 32'(dbg_state), 0);
        rst_n = 1'b1;
        tick();
        check("post_reset_gnt", 32'(o_gnt), 0);

        // ---- single burst of three frames from requester 1 ----
        i_req = 3'b010;
        tick();
        check("sb_gnt", 32'(o_gnt), 32'(3'b010));
        check("sb_owner", 32'(o_owner), 1);
        check("sb_busy", 32'(o_busy), 1);
        for (int f = 0; f < 3; f++) begin
            set_start(1, frames[f], 1'b1);
            tick();
            i_start = '0;
            check("sb_start", 32'(drv_start), 1);
            check("sb_data", 32'(drv_data), 32'(frames[f]));
            check("sb_en_load", 32'(drv_en_load), 1);
            tick();
            check("sb_start_pulse", 32'(drv_start), 0);
            check("sb_data_held", 32'(drv_data), 32'(frames[f]));
            check("sb_no_early_done", 32'(o_done), 0);
            drv_done = 1'b1;
            tick();
            drv_done = 1'b0;
            check("sb_done", 32'(o_done), 32'(3'b010));
        end
        i_req = '0;
        tick();
        check("sb_release_busy", 32'(o_busy), 1);
        tick();
        check("sb_idle_busy", 32'(o_busy), 0);
        check("sb_idle_gnt", 32'(o_gnt), 0);
        check("sb_idle_en_load", 32'(drv_en_load), 0);
        check("sb_owner_hold", 32'(o_owner), 1);

        // ---- table of one-frame bursts with varied request patterns ----
        do_reset();
        tbl[0] = '{3'b010, 16'h0C01, 1'b1, 3'b010};
        tbl[1] = '{3'b011, 16'h0A0F, 1'b0, 3'b001};
        tbl[2] = '{3'b101, 16'h0B07, 1'b1, 3'b100};
        tbl[3] = '{3'b110, 16'h0900, 1'b1, 3'b010};
        tbl[4] = '{3'b111, 16'h01AA, 1'b0, 3'b100};
        tbl[5] = '{3'b001, 16'h0855, 1'b1, 3'b001};
`ifdef MAX7219_IF_ARB_FIXED_PRIO_EN
        tbl[2].exp_gnt = 3'b001;
        tbl[4].exp_gnt = 3'b001;
`endif
        for (int v = 0; v < 6; v++) begin
            i_req = tbl[v].req;
            tick();
            check("tbl_gnt", 32'(o_gnt), 32'(tbl[v].exp_gnt));
            eo = oh_index(tbl[v].exp_gnt);
            check("tbl_owner", 32'(o_owner), 32'(eo));
            set_start(eo, tbl[v].data, tbl[v].en);
            tick();
            i_start = '0;
            check("tbl_start", 32'(drv_start), 1);
            check("tbl_data", 32'(drv_data), 32'(tbl[v].data));
            check("tbl_en_load", 32'(drv_en_load), 32'(tbl[v].en));
            drv_done = 1'b1;
            i_req    = '0;
            tick();
            drv_done = 1'b0;
            check("tbl_done", 32'(o_done), 32'(tbl[v].exp_gnt));
            tick();
            check("tbl_idle_gnt", 32'(o_gnt), 0);
            check("tbl_idle_busy", 32'(o_busy), 0);
        end

        // ---- fairness with all requesters asking ----
        do_reset();
`ifdef MAX7219_IF_ARB_FIXED_PRIO_EN
        ord = '{0, 0, 0, 0};
`else
        ord = '{0, 1, 2, 0};
`endif
        i_req = 3'b111;
        tick();
        for (int b = 0; b < 4; b++) begin
            check("rr_gnt", 32'(o_gnt), 32'(onehot(ord[b])));
            set_start(ord[b], 16'h0300 + 16'(b), 1'b1);
            tick();
            i_start = '0;
            check("rr_start", 32'(drv_start), 1);
            drv_done       = 1'b1;
            i_req[ord[b]]  = 1'b0;
            tick();
            drv_done       = 1'b0;
            check("rr_done", 32'(o_done), 32'(onehot(ord[b])));
            i_req[ord[b]]  = 1'b1;
            tick();
            check("rr_dead_cycle", 32'(o_gnt), 0);
            tick();
        end
        i_req = '0;
        tick();
        tick();

        // ---- watchdog revokes an idle owner ----
        do_reset();
        i_req = 3'b100;
        tick();
        check("wd_gnt", 32'(o_gnt), 32'(3'b100));
        i_req  = 3'b101;
        sticky = 1'b0;
        for (int c = 1; c < TO; c++) begin
            tick();
            if (o_timeout) sticky = 1'b1;
        end
        check("wd_no_early_timeout", 32'(sticky), 0);
        tick();
        check("wd_timeout", 32'(o_timeout), 1);
        tick();
        check("wd_timeout_pulse", 32'(o_timeout), 0);
        check("wd_gnt_dropped", 32'(o_gnt), 0);
        tick();
        check("wd_next_gnt", 32'(o_gnt), 32'(3'b001));
        check("wd_next_owner", 32'(o_owner), 0);
        i_req = '0;
        tick();
        tick();

        // ---- start and request drop in the same cycle; stray starts in XFER ----
        do_reset();
        i_req = 3'b010;
        tick();
        set_start(1, 16'h0A05, 1'b1);
        i_req = '0;
        tick();
        i_start = 3'b101;
        check("sim_start", 32'(drv_start), 1);
        check("sim_data", 32'(drv_data), 32'(16'h0A05));
        tick();
        i_start = '0;
        check("sim_stray_start", 32'(drv_start), 0);
        tick();
        check("sim_stray_start2", 32'(drv_start), 0);
        drv_done = 1'b1;
        tick();
        drv_done = 1'b0;
        check("sim_done", 32'(o_done), 32'(3'b010));
        tick();
        check("sim_released", 32'(o_busy), 0);

        // ---- reset in the middle of a transfer ----
        i_req = 3'b001;
        tick();
        check("rx_gnt", 32'(o_gnt), 32'(3'b001));
        set_start(0, 16'h1234, 1'b1);
        tick();
        i_start = '0;
        check("rx_start", 32'(drv_start), 1);
        i_req = '0;
        rst_n = 1'b0;
        #1;
        check_all_zero("rx_reset_async");
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rx_reset_gnt", 32'(o_gnt), 0);
            check("rx_reset_data", 32'(drv_data), 0);
        end
        rst_n    = 1'b1;
        drv_done = 1'b1;
        tick();
        drv_done = 1'b0;
        check("rx_late_done", 32'(o_done), 0);
        check("rx_busy", 32'(o_busy), 0);
        tick();
        check("rx_late_done2", 32'(o_done), 0);
        i_req = 3'b001;
        tick();
        check("rx_regrant", 32'(o_gnt), 32'(3'b001));
        check("rx_regrant_owner", 32'(o_owner), 0);
        i_req = '0;
        tick();
        tick();

        // ---- randomized run against the transaction-level model ----
        do_reset();
        exp_q.delete();
        prev_req = '0; prev_gnt = '0; exp_done = '0;
        exp_start = 1'b0; in_flight = 1'b0; owner_dropped = 1'b0;
        drv_active = 1'b0; drain = 1'b0;
        m_last = N - 1; m_owner = -1; idle_cnt = 0; drv_cnt = 0; n_grants = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            drain = (cyc >= 3700);
            // observe
            check("rnd_start", 32'(drv_start), 32'(exp_start));
            if (drv_start && exp_q.size() > 0) begin
                fr_exp = exp_q.pop_front();
                check("rnd_data", 32'(drv_data), 32'(fr_exp[W-1:0]));
                check("rnd_en_load", 32'(drv_en_load), 32'(fr_exp[W]));
                drv_active = 1'b1;
                drv_cnt    = $urandom_range(0, 3);
            end
            check("rnd_done", 32'(o_done), 32'(exp_done));
            if (exp_done != '0) in_flight = 1'b0;
            check("rnd_timeout", 32'(o_timeout), 0);
            if (prev_gnt == '0 && o_gnt != '0) begin
                m_owner = model_winner(prev_req, m_last);
                check("rnd_gnt", 32'(o_gnt), 32'(onehot(m_owner)));
                check("rnd_owner", 32'(o_owner), 32'(m_owner));
                if (m_owner >= 0) m_last = m_owner;
                idle_cnt      = 0;
                in_flight     = 1'b0;
                owner_dropped = 1'b0;
                n_grants++;
            end
            if (o_gnt == '0) owner_dropped = 1'b0;
            prev_gnt = o_gnt;
            // drive
            i_start   = '0;
            drv_done  = 1'b0;
            exp_start = 1'b0;
            exp_done  = '0;
            if (drv_active) begin
                if (drv_cnt == 0) begin
                    drv_done   = 1'b1;
                    drv_active = 1'b0;
                    exp_done   = onehot(m_owner);
                    if ((drain || $urandom_range(0, 3) == 0) && m_owner >= 0) begin
                        i_req[m_owner] = 1'b0;
                        owner_dropped  = 1'b1;
                    end
                end else begin
                    drv_cnt--;
                end
            end else if (o_gnt != '0 && !owner_dropped && !in_flight && m_owner >= 0) begin
                r = drain ? 5 : $urandom_range(0, 9);
                if (!drain && (idle_cnt >= 8 || r < 5)) begin
                    rd  = W'($urandom);
                    ren = 1'($urandom_range(0, 1));
                    set_start(m_owner, rd, ren);
                    exp_q.push_back({ren, rd});
                    exp_start = 1'b1;
                    in_flight = 1'b1;
                    idle_cnt  = 0;
                    if (r == 0) begin
                        i_req[m_owner] = 1'b0;
                        owner_dropped  = 1'b1;
                    end
                end else if (r < 7) begin
                    i_req[m_owner] = 1'b0;
                    owner_dropped  = 1'b1;
                end else begin
                    idle_cnt++;
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                sk = $urandom_range(0, N - 1);
                if (!(o_gnt != '0 && sk == m_owner)) begin
                    i_start[sk]      = 1'b1;
                    i_data[sk*W +: W] = W'($urandom);
                end
            end
            for (int k = 0; k < N; k++) begin
                if (!drain && !i_req[k] && !(o_gnt != '0 && k == m_owner)
                    && $urandom_range(0, 3) == 0) begin
                    i_req[k] = 1'b1;
                end
            end
            prev_req = i_req;
        end
        check("rnd_queue_empty", 32'(exp_q.size()), 0);
        check("rnd_final_busy", 32'(o_busy), 0);
        check("rnd_grants_seen", 32'(n_grants > 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/max7219_if_arbiter.md
Name: max7219_if_arbiter

Overview:
- Shares one max7219_if serial driver between G_NB_REQ requesters, for example max7219_scroller_ctrl, a static pattern display controller and the MAX7219 init/config sequencer.
- Each requester owns the driver for a burst: a sequence of 16-bit frames, each ended by the driver's done.
- Grants are round-robin with a registered handshake.
- Owner start/en_load/data are forwarded to the driver, and the driver's done is routed back to the owner only.
- An idle watchdog revokes a grant from an owner that stalls.

Parameters:
- G_NB_REQ, 3, number of requesters (2..8).
- G_DATA_WIDTH, 16, MAX7219 frame width (address byte and data byte).
- G_IDLE_TIMEOUT, 1024, cycles an owner may hold the grant without issuing start; 0 disables the watchdog.
- G_TIMEOUT_WIDTH, 16, width of the watchdog counter; must satisfy G_IDLE_TIMEOUT < 2**G_TIMEOUT_WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  G_NB_REQ  per-requester bus request, level, held for the whole burst.
- o_gnt  out  G_NB_REQ  one-hot grant, registered.
- i_start  in  G_NB_REQ  per-requester frame start pulse.
- i_en_load  in  G_NB_REQ  per-requester LOAD enable for the frame.
- i_data  in  G_NB_REQ*G_DATA_WIDTH  per-requester frame data; requester k uses slice [k*G_DATA_WIDTH +: G_DATA_WIDTH].
- o_done  out  G_NB_REQ  per-requester frame done pulse.
- o_max7219_if_start  out  1  start pulse to max7219_if.
- o_max7219_if_en_load  out  1  en_load to max7219_if.
- o_max7219_if_data  out  G_DATA_WIDTH  data to max7219_if.
- i_max7219_if_done  in  1  done pulse from max7219_if.
- o_owner  out  3  index of the current owner; valid while o_busy=1.
- o_busy  out  1  high from grant until release.
- o_timeout  out  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (async, rst_n=0): every output is 0, FSM is IDLE, RR pointer is 0, watchdog counter is 0. Any burst in flight is abandoned; the driver is not aborted, and a done arriving after reset release is ignored because the FSM is in IDLE.
- States: IDLE, GRANT, XFER, RELEASE.
- IDLE:
  - If i_req != 0, select a winner by scanning from the RR pointer upward, wrapping modulo G_NB_REQ.
  - Next cycle: o_gnt[winner]=1, o_owner=winner, o_busy=1, go to GRANT.
  - Latency from i_req to o_gnt is 1 cycle.
- GRANT:
  - Owner i_start=1: register i_data and i_en_load of the owner onto the driver outputs. Pulse o_max7219_if_start for 1 cycle (forwarding latency 1 cycle). Clear the watchdog. Go to XFER.
  - i_start from non-owners is ignored and never queued.
  - Owner i_req=0 with i_start=0: go to RELEASE.
  - If i_req=0 and i_start=1 arrive in the same cycle, start wins; the frame is sent and release happens after it.
  - Watchdog increments each GRANT cycle. When it reaches G_IDLE_TIMEOUT, pulse o_timeout and go to RELEASE.
- XFER:
  - o_max7219_if_data and o_max7219_if_en_load are held stable.
  - On i_max7219_if_done, pulse o_done[owner] in the next cycle, then return to GRANT, or go to RELEASE if the owner's i_req=0.
  - Owner i_start during XFER is ignored (protocol violation).
  - No watchdog counting in XFER.
- RELEASE (1 cycle):
  - o_gnt=0, o_busy=0, o_max7219_if_en_load=0.
  - RR pointer := (owner+1) mod G_NB_REQ.
  - Go to IDLE. This guarantees one dead cycle between owners.
- Fairness: with all requesters requesting continuously, the grant order is 0,1,2,0,...; no requester waits more than G_NB_REQ-1 bursts.
- o_owner holds its last value in IDLE.

Optional Feature:
- MAX7219_IF_ARB_FIXED_PRIO_EN.
- Defined: the winner is the lowest-index requesting i_req, and the RR pointer is unused.
- Undefined: round-robin as above.
- Everything else is identical in both builds.

Test Plan:
- Single burst: after reset, i_req=3'b010; o_gnt=3'b010 one cycle later.
  - Three i_start with data 16'h0C01, 16'h0F00, 16'h0101 appear on o_max7219_if_data in order, each with a start pulse 1 cycle after the request.
  - o_done[1] pulses 3 times; o_done[0] and o_done[2] stay 0.
  - i_req=0 gives o_busy=0 after RELEASE.
- Round-robin: i_req=3'b111 held, each requester sends 1 frame then drops and re-raises its request.
  - Grant order is 0,1,2,0.
  - Each requester gets exactly one dead cycle between grants.
- Fixed priority (MAX7219_IF_ARB_FIXED_PRIO_EN): same stimulus; requester 0 wins every arbitration.
- Watchdog: G_IDLE_TIMEOUT=16, owner 2 requests and never starts.
  - o_timeout pulses 16 cycles after the grant.
  - o_gnt drops, and requester 0 (still waiting) is granted next.
- Simultaneous events: the owner drops i_req in the same cycle as i_start with data 16'h0A05.
  - The frame is sent and o_done is pulsed, then release.
  - i_start from a non-owner during XFER causes no extra o_max7219_if_start.
- Reset mid-XFER: rst_n=0 for 3 cycles, then a late i_max7219_if_done arrives.
  - All outputs are 0 during reset; no o_done after it.
  - A new i_req=3'b001 is granted normally.
